// File: rtl/sw_input_port.sv
// Memory-mapped slide-switch port: 2-flop sync, tick-sampled debounce, level/capture/count registers.
// Read data Q is registered (1-cycle latency); writes to offset 1 clear capture bits, writes to offset 2 load count.
module sw_input_port #(
    parameter int N          = 9,
    parameter int DEB_CYCLES = 50000,
    parameter int CW         = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [N-1:0]  SW,
    input  logic          Sel,
    input  logic [1:0]    Addr,
    input  logic          W,
    input  logic [15:0]   Data,
    output logic [15:0]   Q,
    output logic          Changed
);

    localparam logic [CW-1:0] TICK_LAST = CW'(DEB_CYCLES - 1);

    logic [N-1:0]  meta_q, sync_q;
    logic [N-1:0]  sample_q;
    logic [N-1:0]  stable_q, stable_d;
    logic [N-1:0]  capture_q, capture_d;
    logic [N-1:0]  evt;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]    count_q, count_d;
    logic [15:0]   q_q, q_d;
    logic          changed_q;
    logic          tick;
    logic          wr_cap, wr_cnt;
    logic          unused_data;

    assign unused_data = ^Data[15:N];

    // A bit only moves when two consecutive ticks agree and differ from the current level.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        evt        = tick ? (~(sync_q ^ sample_q) & (sync_q ^ stable_q)) : '0;
        stable_d   = stable_q ^ evt;
    end

    always_comb begin
        wr_cap    = Sel & W & (Addr == 2'd1);
        wr_cnt    = Sel & W & (Addr == 2'd2);
        capture_d = (capture_q & ~(wr_cap ? Data[N-1:0] : '0)) | evt;
        if (wr_cnt)
            count_d = Data[7:0];
        else if (|evt)
            count_d = count_q + 8'd1;
        else
            count_d = count_q;
    end

    always_comb begin
        q_d = 16'h0000;
        if (Sel) begin
            case (Addr)
                2'd0:    q_d = 16'(stable_q);
                2'd1:    q_d = 16'(capture_q);
                2'd2:    q_d = {8'h00, count_q};
                default: q_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            meta_q     <= '0;
            sync_q     <= '0;
            sample_q   <= '0;
            stable_q   <= '0;
            capture_q  <= '0;
            count_q    <= '0;
            tick_cnt_q <= '0;
            q_q        <= '0;
            changed_q  <= 1'b0;
        end else begin
            meta_q     <= SW;
            sync_q     <= meta_q;
            if (tick)
                sample_q <= sync_q;
            stable_q   <= stable_d;
            capture_q  <= capture_d;
            count_q    <= count_d;
            tick_cnt_q <= tick_cnt_d;
            q_q        <= q_d;
            changed_q  <= |capture_d;
        end
    end

    assign Q       = q_q;
    assign Changed = changed_q;

endmodule

// File: tb/tb_sw_input_port.sv
// Bench for sw_input_port with a short debounce period and a behavioural reference model.
module tb_sw_input_port;

    localparam int NB  = 9;
    localparam int DEB = 4;

    logic          Clock;
    logic          Reset;
    logic [NB-1:0] SW;
    logic          Sel;
    logic [1:0]    Addr;
    logic          W;
    logic [15:0]   Data;
    logic [15:0]   Q;
    logic          Changed;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [NB-1:0] m_sample, m_stable, m_cap;
    logic [7:0]    m_cnt;
    logic [15:0]   m_q;
    int            cyc;
    logic [NB-1:0] sw_hist[$];

    sw_input_port #(.N(NB), .DEB_CYCLES(DEB), .CW(3)) dut (
        .Clock(Clock), .Reset(Reset), .SW(SW), .Sel(Sel), .Addr(Addr),
        .W(W), .Data(Data), .Q(Q), .Changed(Changed)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Change events predicted for the upcoming edge.
    function automatic logic [NB-1:0] model_events();
        logic [NB-1:0] e;
        logic [NB-1:0] s;
        e = '0;
        s = sw_hist[0];
        if (cyc % DEB == DEB - 1)
            for (int i = 0; i < NB; i++)
                if (s[i] == m_sample[i] && s[i] != m_stable[i])
                    e[i] = 1'b1;
        return e;
    endfunction

    task automatic cycle();
        logic [NB-1:0] ev, capn, sw_now;
        logic [15:0]   qn;
        logic [7:0]    cntn;
        logic          wr, tk;
        ev = model_events();
        tk = (cyc % DEB == DEB - 1);
        wr = Sel && W;
        qn = 16'h0;
        if (Sel) begin
            if (Addr == 2'd0) qn = {7'b0, m_stable};
            else if (Addr == 2'd1) qn = {7'b0, m_cap};
            else if (Addr == 2'd2) qn = {8'b0, m_cnt};
        end
        capn = (m_cap & ~((wr && Addr == 2'd1) ? Data[NB-1:0] : 9'h0)) | ev;
        if (wr && Addr == 2'd2) cntn = Data[7:0];
        else if (ev != 0)       cntn = m_cnt + 8'd1;
        else                    cntn = m_cnt;
        sw_now = SW;
        @(posedge Clock);
        #1;
        if (Reset) begin
            m_sample = '0; m_stable = '0; m_cap = '0; m_cnt = '0; m_q = '0;
            cyc = 0;
            sw_hist = '{9'h0, 9'h0};
        end else begin
            if (tk) m_sample = sw_hist[0];
            m_stable = m_stable ^ ev;
            m_cap    = capn;
            m_cnt    = cntn;
            m_q      = qn;
            cyc      = cyc + 1;
            sw_hist.push_back(sw_now);
            void'(sw_hist.pop_front());
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; SW = '0; Sel = 1'b0; W = 1'b0; Addr = 2'd0; Data = 16'h0;
        cycle();
        cycle();
        Reset = 1'b0;
        for (int a = 0; a < 3; a++) begin
            Sel = 1'b1; Addr = 2'(a);
            cycle();
            checks++;
            if (Q !== 16'h0000) begin
                errors++; $display("FAIL reset_read%0d: got %h expected 0000", a, Q);
            end
            checks++;
            if (Changed !== 1'b0) begin
                errors++; $display("FAIL reset_changed: got %b expected 0", Changed);
            end
        end
    endtask

    task automatic test_level();
        logic [15:0] exp_v[3];
        exp_v = '{16'h0005, 16'h0005, 16'h0001};
        SW = 9'h005; Sel = 1'b1; Addr = 2'd0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            checks++;
            if (Q !== m_q) begin
                errors++; $display("FAIL level_track: got %h expected %h", Q, m_q);
            end
        end
        for (int a = 0; a < 3; a++) begin
            Addr = 2'(a);
            cycle();
            checks++;
            if (Q !== exp_v[a]) begin
                errors++; $display("FAIL level_read%0d: got %h expected %h", a, Q, exp_v[a]);
            end
        end
        checks++;
        if (Changed !== 1'b1) begin
            errors++; $display("FAIL level_changed: got %b expected 1", Changed);
        end
    endtask

    task automatic test_w1c();
        Sel = 1'b1; W = 1'b1; Addr = 2'd1; Data = 16'h0001;
        cycle();
        W = 1'b0;
        cycle();
        checks++;
        if (Q !== 16'h0004) begin
            errors++; $display("FAIL w1c_bit0: got %h expected 0004", Q);
        end
        W = 1'b1; Data = 16'h0004;
        cycle();
        W = 1'b0;
        cycle();
        checks++;
        if (Q !== 16'h0000) begin
            errors++; $display("FAIL w1c_bit2: got %h expected 0000", Q);
        end
        checks++;
        if (Changed !== 1'b0) begin
            errors++; $display("FAIL w1c_changed: got %b expected 0", Changed);
        end
    endtask

    task automatic test_glitch();
        SW = 9'h00D; Sel = 1'b1; Addr = 2'd0;
        cycle();
        SW = 9'h005;
        for (int k = 0; k < 20; k++) begin
            cycle();
            checks++;
            if (Q !== m_q) begin
                errors++; $display("FAIL glitch_track: got %h expected %h", Q, m_q);
            end
        end
        checks++;
        if (Q !== 16'h0005) begin
            errors++; $display("FAIL glitch_level: got %h expected 0005", Q);
        end
        Addr = 2'd1;
        cycle();
        checks++;
        if (Q !== 16'h0000) begin
            errors++; $display("FAIL glitch_capture: got %h expected 0000", Q);
        end
    endtask

    task automatic test_wrap();
        Sel = 1'b1; W = 1'b1; Addr = 2'd2; Data = 16'h00FF;
        cycle();
        W = 1'b0; SW = 9'h004;
        cycle();
        checks++;
        if (Q !== 16'h00FF) begin
            errors++; $display("FAIL wrap_load: got %h expected 00ff", Q);
        end
        for (int k = 0; k < 11; k++) begin
            cycle();
            checks++;
            if (Q !== m_q) begin
                errors++; $display("FAIL wrap_track: got %h expected %h", Q, m_q);
            end
        end
        checks++;
        if (Q !== 16'h0000) begin
            errors++; $display("FAIL wrap_count: got %h expected 0000", Q);
        end
    endtask

    task automatic test_set_wins();
        logic [NB-1:0] ev;
        bit found;
        Sel = 1'b1; W = 1'b1; Addr = 2'd1; Data = 16'h01FF;
        cycle();
        W = 1'b0; SW = 9'h005;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            ev = model_events();
            if (ev[0]) begin
                W = 1'b1; Addr = 2'd1; Data = 16'h0001; found = 1'b1;
            end else begin
                W = 1'b0;
            end
            cycle();
        end
        W = 1'b0; Addr = 2'd1;
        cycle();
        checks++;
        if (!found) begin
            errors++; $display("FAIL set_wins_timeout: got no event expected event within 20 cycles");
        end
        checks++;
        if (Q !== 16'h0001) begin
            errors++; $display("FAIL set_wins: got %h expected 0001", Q);
        end
    endtask

    task automatic test_reset_mid();
        SW = 9'h1F0; Sel = 1'b0; W = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        Reset = 1'b1; Sel = 1'b1; Addr = 2'd1;
        cycle();
        Reset = 1'b0;
        checks++;
        if (Q !== 16'h0000 || Changed !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got %h/%b expected 0000/0", Q, Changed);
        end
        for (int a = 0; a < 3; a++) begin
            Addr = 2'(a);
            cycle();
            checks++;
            if (Q !== 16'h0000) begin
                errors++; $display("FAIL reset_mid_read%0d: got %h expected 0000", a, Q);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) SW = 9'($urandom);
            Sel   = ($urandom_range(0, 3) != 0);
            Addr  = 2'($urandom);
            W     = ($urandom_range(0, 7) == 0);
            Data  = 16'($urandom);
            Reset = ($urandom_range(0, 499) == 0);
            cycle();
            checks++;
            if (Q !== m_q) begin
                errors++; $display("FAIL random_q: got %h expected %h at step %0d", Q, m_q, k);
            end
            checks++;
            if (Changed !== (m_cap != 0)) begin
                errors++; $display("FAIL random_changed: got %b expected %b at step %0d", Changed, (m_cap != 0), k);
            end
        end
        Reset = 1'b0;
    endtask

    initial begin
        m_sample = '0; m_stable = '0; m_cap = '0; m_cnt = '0; m_q = '0; cyc = 0;
        sw_hist = '{9'h0, 9'h0};
        test_reset();
        test_level();
        test_w1c();
        test_glitch();
        test_wrap();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
